hamming_frame_encoder: RTL and testbench
========================================

# hamming_frame_encoder

Upstream feeder for the 8-bit serializer: accepts payload bytes over a valid/ready handshake, buffers them in a small FIFO, and encodes each nibble into an extended Hamming(8,4) codeword. It presents each codeword on a parallel bus, held stable for exactly one 8-cycle serializer frame. Its internal slot counter runs in lockstep with the serializer's bit counter; both come out of the same reset. The serializer therefore always samples a complete, stable codeword, MSB first.

## Interface
Parameters:
- DEPTH, 4, FIFO depth in bytes; power of two, ≥2
- IDLE_WORD, 8'h00, codeword driven when no payload is available

Ports:
- clock  input  1  sole clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; must share assertion with the serializer's reset
- io_in_data  input  8  payload byte
- io_in_valid  input  1  io_in_data valid this cycle
- io_in_ready  output  1  FIFO can accept a byte this cycle
- io_output  output  8  codeword to serializer parallel input
- io_frame_valid  output  1  io_output carries payload (1) or IDLE_WORD (0)
- io_slot  output  3  current slot index (0..7) of the frame

## Operation
- Slot counter: 3-bit, reset to 0, increments every cycle, wraps 7→0. A "boundary edge" is a rising edge with slot==7.
- FIFO: DEPTH entries, count 0..DEPTH. io_in_ready = (count < DEPTH), with no full-bypass. A push occurs on an edge with valid && ready. A pop occurs only on boundary edges.
- Nibble order: high nibble first, then low nibble. Each byte occupies two consecutive frames (16 cycles).
- State: IDLE, HI_SENT, both in a 1-bit low_pending flag plus a held low-nibble register.
- At each boundary edge:
  - low_pending=1: load enc(low nibble), clear low_pending, frame_valid=1.
  - else FIFO non-empty: pop, load enc(high nibble), store the low nibble, set low_pending, frame_valid=1.
  - else: load IDLE_WORD, frame_valid=0.
- At non-boundary edges, io_output and io_frame_valid hold.
- Encoding, with nibble d3..d0 (d3 = MSB):
  - p1 = d3^d2^d0; p2 = d3^d1^d0; p4 = d2^d1^d0.
  - io_output[7:1] = {p1,p2,d3,p4,d2,d1,d0} (Hamming positions 1..7).
  - io_output[0] = XOR of bits [7:1] (overall parity, even weight).
- Push and pop on the same boundary edge: both take effect, count unchanged. The popped entry is the oldest one present before the edge. A byte pushed on edge E is never popped on edge E.

## Timing
- Reset values: io_output=IDLE_WORD, io_frame_valid=0, io_slot=0, FIFO empty, low_pending=0, io_in_ready=1 (combinational from count).
- Frame n spans the cycles with slot 0..7. io_output changes only in the cycle after a boundary edge, i.e. when slot becomes 0.
- The first frame after reset is always IDLE_WORD.
- Latency, push edge to first codeword: the push edge with slot==6 gives the minimum, 2 cycles. A push on a boundary edge gives the maximum, 9 cycles plus queued work.
- Throughput: 1 byte per 16 cycles. Sustained input at a faster rate fills the FIFO, and io_in_ready then drops until the next pop.
- Reset mid-operation: all buffered bytes and any pending low nibble are discarded. Outputs return to reset values on the edge following reset assertion.

## Test plan
- Reset values: hold reset 3 cycles, release -> io_output=8'h00, io_frame_valid=0, io_slot counts 0..7 and wraps, io_in_ready=1.
- Single byte: push 8'hA5 at slot 2 -> after the next boundary, one frame of 8'hB4 (frame_valid=1), then one frame of 8'h4B, then IDLE_WORD with frame_valid=0.
- Codebook: push 8'h0F, then 8'hF0, then 8'h00..8'hFF sweep -> per nibble, 0→8'h00, F→8'hFF. All 16 codewords match the encoding rule, have even weight, and have pairwise Hamming distance ≥4.
- Backpressure: hold io_in_valid=1 with bytes 1,2,3,4,5,6 from reset -> ready deasserts after 4 accepts. Ready reasserts for exactly one accept per 16 cycles. Output order is 1,2,3,4,5,6 and no byte is lost or duplicated.
- Boundary collision: FIFO empty, push 8'h3C exactly on a boundary edge -> that boundary loads IDLE_WORD. The next boundary loads enc(3)=8'h87, followed by enc(C)=8'h78.
- Reset mid-frame: queue 3 bytes, assert reset at slot 4 of a payload frame -> io_output=IDLE_WORD, frame_valid=0, and FIFO empty after release. Bytes pushed after release are output with no stale data.
- Integration: connect to the serializer and compare the serial stream against the expected MSB-first concatenation of codewords, including idle frames.

Source files
------------

// File: rtl/hamming_frame_encoder_if.sv
// Bus between the payload source, the Hamming frame encoder and the serializer.
// The source side feeds bytes over valid/ready. The encoder side presents the
// held codeword, its payload flag and the current slot index.
interface hamming_frame_encoder_if;
  logic [7:0] io_in_data;
  logic       io_in_valid;
  logic       io_in_ready;
  logic [7:0] io_output;
  logic       io_frame_valid;
  logic [2:0] io_slot;

  modport master (
    output io_in_data,
    output io_in_valid,
    input  io_in_ready,
    input  io_output,
    input  io_frame_valid,
    input  io_slot
  );

  modport slave (
    input  io_in_data,
    input  io_in_valid,
    output io_in_ready,
    output io_output,
    output io_frame_valid,
    output io_slot
  );
endinterface

// File: rtl/hamming_frame_encoder.sv
// Hamming frame encoder: buffers payload bytes in a small FIFO and presents one
// extended Hamming(8,4) codeword per 8-cycle serializer frame. The high nibble
// goes first and the low nibble second, so each byte takes two frames. A slot
// counter runs in lockstep with the serializer's bit counter. The codeword only
// changes on the edge that ends slot 7.
module hamming_frame_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [7:0]  IDLE_WORD = 8'h00
) (
  input  logic                    clock,
  input  logic                    reset,
  hamming_frame_encoder_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {
    IDLE,
    HI_SENT
  } state_t;

  logic [2:0]    slot_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rdPtr_q;
  logic [AW-1:0] wrPtr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  state_t        state_q;
  logic [3:0]    lowNibble_q;
  logic [7:0]    output_q;
  logic          frameValid_q;

  logic          boundary;
  logic          push;
  logic          pop;
  logic [7:0]    headByte;

  // Extended Hamming(8,4): bits [7:1] are Hamming positions 1..7 and bit 0
  // makes the total weight even.
  function automatic logic [7:0] encodeNibble(input logic [3:0] d);
    logic       p1;
    logic       p2;
    logic       p4;
    logic [6:0] h;
    p1 = d[3] ^ d[2] ^ d[0];
    p2 = d[3] ^ d[1] ^ d[0];
    p4 = d[2] ^ d[1] ^ d[0];
    h  = {p1, p2, d[3], p4, d[2], d[1], d[0]};
    return {h, ^h};
  endfunction

  assign boundary           = (slot_q == 3'd7);
  assign bus.io_in_ready    = (count_q < (AW+1)'(DEPTH));
  assign push               = bus.io_in_valid && bus.io_in_ready;
  assign pop                = boundary && (state_q == IDLE) && (count_q != '0);
  assign headByte           = mem_q[rdPtr_q];
  assign bus.io_output      = output_q;
  assign bus.io_frame_valid = frameValid_q;
  assign bus.io_slot        = slot_q;

  // Occupancy stays unchanged when a push and a pop land on the same edge.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage needs no reset because the pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wrPtr_q] <= bus.io_in_data;
    end
  end

  // FIFO pointers and occupancy. Reset discards every buffered byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + AW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  // Slot counter and frame FSM. The registered outputs are reloaded only at
  // frame boundaries, so the serializer always sees a stable word.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q       <= 3'd0;
      state_q      <= IDLE;
      lowNibble_q  <= 4'd0;
      output_q     <= IDLE_WORD;
      frameValid_q <= 1'b0;
    end else begin
      slot_q <= slot_q + 3'd1;
      if (boundary) begin
        if (state_q == HI_SENT) begin
          output_q     <= encodeNibble(lowNibble_q);
          frameValid_q <= 1'b1;
          state_q      <= IDLE;
        end else if (pop) begin
          output_q     <= encodeNibble(headByte[7:4]);
          lowNibble_q  <= headByte[3:0];
          frameValid_q <= 1'b1;
          state_q      <= HI_SENT;
        end else begin
          output_q     <= IDLE_WORD;
          frameValid_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hamming_frame_encoder.sv
// Testbench for hamming_frame_encoder. A queue-based reference model predicts
// the codeword, payload flag, slot and ready on every cycle. Directed vector
// tables and hand-written sequences then pin down the multi-cycle corner cases
// against literal codewords.
module tb_hamming_frame_encoder;

  localparam int         DEPTH = 4;
  localparam logic [7:0] IDLE  = 8'h00;

  typedef struct {
    logic [7:0] data;
    int         pushSlot;
    int         expLat;
    logic [7:0] expHi;
    logic [7:0] expLo;
  } vec_t;

  logic clock = 1'b0;
  logic reset;

  hamming_frame_encoder_if bus ();

  hamming_frame_encoder #(
    .DEPTH     (DEPTH),
    .IDLE_WORD (IDLE)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock with a 10-time-unit period.
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  int         mSlot;
  logic [7:0] mByteQ [$];
  bit         mPend;
  logic [3:0] mPendNib;
  logic [7:0] mOut;
  bit         mFv;

  logic [7:0] sampOut;
  logic       sampFv;
  logic       sampReady;
  logic [2:0] sampSlot;

  logic [7:0] frameLog [$];
  bit         logFrames = 1'b0;

  logic [7:0] codeBook [16];
  vec_t       vecs [8];

  // Hamming code built from position arithmetic: data sits at positions 3, 5, 6
  // and 7. Each parity position p covers every position whose index has bit p set.
  function automatic logic [7:0] refEnc(input logic [3:0] nib);
    logic       hp [8];
    logic [7:0] cw;
    logic       par;
    for (int k = 0; k < 8; k++) hp[k] = 1'b0;
    hp[3] = nib[3];
    hp[5] = nib[2];
    hp[6] = nib[1];
    hp[7] = nib[0];
    for (int p = 1; p < 8; p = p * 2) begin
      par = 1'b0;
      for (int j = 1; j < 8; j++) begin
        if (j != p && (j & p) != 0) par = par ^ hp[j];
      end
      hp[p] = par;
    end
    cw = 8'h00;
    for (int k = 1; k < 8; k++) cw[8-k] = hp[k];
    cw[0] = ^cw[7:1];
    return cw;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mSlot = 0;
    mByteQ.delete();
    mPend = 1'b0;
    mPendNib = 4'h0;
    mOut = IDLE;
    mFv = 1'b0;
  endtask

  // One clock cycle. The task samples and checks the outputs at the negedge,
  // then drives the inputs for the coming rising edge and advances the model
  // across that edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    bit         pushOk;
    logic [7:0] b;
    @(negedge clock);
    sampOut   = bus.io_output;
    sampFv    = bus.io_frame_valid;
    sampReady = bus.io_in_ready;
    sampSlot  = bus.io_slot;
    checkOutput("slot", sampSlot, mSlot);
    checkOutput("codeword", sampOut, mOut);
    checkOutput("frame_valid", sampFv, mFv);
    checkOutput("in_ready", sampReady, (mByteQ.size() < DEPTH));
    if (logFrames && sampSlot == 3'd0 && sampFv === 1'b1) frameLog.push_back(sampOut);
    reset           = r;
    bus.io_in_valid = v;
    bus.io_in_data  = d;
    if (r) begin
      modelReset();
    end else begin
      pushOk = v && (mByteQ.size() < DEPTH);
      if (mSlot == 7) begin
        if (mPend) begin
          mOut = refEnc(mPendNib);
          mPend = 1'b0;
          mFv = 1'b1;
        end else if (mByteQ.size() > 0) begin
          b = mByteQ.pop_front();
          mOut = refEnc(b[7:4]);
          mPendNib = b[3:0];
          mPend = 1'b1;
          mFv = 1'b1;
        end else begin
          mOut = IDLE;
          mFv = 1'b0;
        end
      end
      if (pushOk) mByteQ.push_back(d);
      mSlot = (mSlot + 1) % 8;
    end
    @(posedge clock);
  endtask

  task automatic waitIdleAt(input int slot);
    int guard;
    guard = 0;
    while (!(mByteQ.size() == 0 && !mPend && !mFv && mSlot == slot) && guard < 64) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      guard++;
    end
    checkOutput("idle_wait_timeout", (guard < 64), 1);
  endtask

  task automatic waitFrameValid(output int lat);
    lat = 0;
    do begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      lat++;
    end while (sampFv !== 1'b1 && lat < 40);
  endtask

  initial begin
    int         lat;
    int         b;
    int         guard;
    int         nextByte;
    int         accepts [$];
    int         expAcc [6];
    logic       readyAt [128];
    logic [7:0] cw [16];
    bit         staleSeen;

    codeBook = '{8'h00, 8'hD2, 8'h55, 8'h87, 8'h99, 8'h4B, 8'hCC, 8'h1E,
                 8'hE1, 8'h33, 8'hB4, 8'h66, 8'h78, 8'hAA, 8'h2D, 8'hFF};
    vecs[0] = '{8'hA5, 2, 6, 8'hB4, 8'h4B};
    vecs[1] = '{8'h0F, 6, 2, 8'h00, 8'hFF};
    vecs[2] = '{8'hF0, 5, 3, 8'hFF, 8'h00};
    vecs[3] = '{8'h3C, 7, 9, 8'h87, 8'h78};
    vecs[4] = '{8'h12, 0, 8, 8'hD2, 8'h55};
    vecs[5] = '{8'h9E, 4, 4, 8'h33, 8'h2D};
    vecs[6] = '{8'hD6, 1, 7, 8'hAA, 8'hCC};
    vecs[7] = '{8'h78, 3, 5, 8'h1E, 8'hE1};
    expAcc = '{1, 2, 3, 4, 9, 25};

    reset = 1'b1;
    bus.io_in_valid = 1'b0;
    bus.io_in_data = 8'h00;
    modelReset();
    repeat (3) @(posedge clock);

    $display("[TB] reset values");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("rst_slot", sampSlot, i % 8);
      checkOutput("rst_word", sampOut, 8'h00);
      checkOutput("rst_valid", sampFv, 0);
      checkOutput("rst_ready", sampReady, 1);
    end

    $display("[TB] directed single-byte vectors");
    for (int i = 0; i < 8; i++) begin
      waitIdleAt(vecs[i].pushSlot);
      applyStimulus(1'b1, vecs[i].data, 1'b0);
      checkOutput("push_ready", sampReady, 1);
      waitFrameValid(lat);
      checkOutput("latency", lat, vecs[i].expLat);
      checkOutput("hi_word", sampOut, vecs[i].expHi);
      repeat (8) applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("lo_word", sampOut, vecs[i].expLo);
      checkOutput("lo_valid", sampFv, 1);
      repeat (8) applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("after_word", sampOut, IDLE);
      checkOutput("after_valid", sampFv, 0);
    end

    $display("[TB] codebook sweep");
    waitIdleAt(0);
    frameLog.delete();
    logFrames = 1'b1;
    b = 0;
    guard = 0;
    while (b < 256 && guard < 6000) begin
      applyStimulus(1'b1, 8'(b), 1'b0);
      if (sampReady === 1'b1) b++;
      guard++;
    end
    repeat (100) applyStimulus(1'b0, 8'h00, 1'b0);
    logFrames = 1'b0;
    checkOutput("sweep_frames", frameLog.size(), 512);
    if (frameLog.size() == 512) begin
      for (int n = 0; n < 16; n++) begin
        cw[n] = frameLog[32*n];
        checkOutput("codebook", cw[n], codeBook[n]);
        checkOutput("even_weight", $countones(cw[n]) % 2, 0);
      end
      for (int k = 0; k < 256; k++) begin
        checkOutput("sweep_hi", frameLog[2*k], codeBook[k/16]);
        checkOutput("sweep_lo", frameLog[2*k+1], codeBook[k%16]);
      end
      for (int i = 0; i < 16; i++) begin
        for (int j = i + 1; j < 16; j++) begin
          checkOutput("min_distance", ($countones(cw[i] ^ cw[j]) >= 4), 1);
        end
      end
    end

    $display("[TB] backpressure");
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1);
    frameLog.delete();
    logFrames = 1'b1;
    nextByte = 1;
    for (int cyc = 1; cyc <= 120; cyc++) begin
      applyStimulus(nextByte <= 6, 8'(nextByte), 1'b0);
      readyAt[cyc] = sampReady;
      if (nextByte <= 6 && sampReady === 1'b1) begin
        accepts.push_back(cyc);
        nextByte++;
      end
    end
    logFrames = 1'b0;
    checkOutput("ready_full", readyAt[5], 0);
    checkOutput("ready_after_pop", readyAt[9], 1);
    checkOutput("accept_count", accepts.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < accepts.size()) checkOutput("accept_cycle", accepts[i], expAcc[i]);
    end
    checkOutput("bp_frames", frameLog.size(), 12);
    for (int k = 0; k < 6; k++) begin
      if (2*k + 1 < frameLog.size()) begin
        checkOutput("bp_hi", frameLog[2*k], codeBook[0]);
        checkOutput("bp_lo", frameLog[2*k+1], codeBook[k+1]);
      end
    end

    $display("[TB] reset mid-frame");
    waitIdleAt(0);
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0);
    guard = 0;
    while (!(mFv && mSlot == 4) && guard < 40) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      guard++;
    end
    checkOutput("reset_wait_timeout", (guard < 40), 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("midrst_word", sampOut, IDLE);
    checkOutput("midrst_valid", sampFv, 0);
    checkOutput("midrst_slot", sampSlot, 0);
    checkOutput("midrst_ready", sampReady, 1);
    staleSeen = 1'b0;
    repeat (24) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      if (sampFv !== 1'b0) staleSeen = 1'b1;
    end
    checkOutput("no_stale", staleSeen, 0);
    applyStimulus(1'b1, 8'h5A, 1'b0);
    waitFrameValid(lat);
    checkOutput("post_rst_hi", sampOut, codeBook[5]);
    repeat (8) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("post_rst_lo", sampOut, codeBook[10]);

    $display("[TB] randomized traffic");
    repeat (3000) begin
      applyStimulus(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 599) == 0));
    end
    applyStimulus(1'b0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
